// File: rtl/dot_product_stream.sv
// rtl/dot_product_stream.sv - streaming signed dot product: input reg, products, adder tree, accumulate
// Optional saturation of the result: `define DOT_PRODUCT_SATURATE_EN
module dot_product_stream #(
  parameter int WIDTH       = 32,
  parameter int LANES       = 4,
  parameter int FIXED_POINT = 0,
  parameter int FRAC        = WIDTH / 2
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [LANES*WIDTH-1:0]   x_in,
  input  logic [LANES*WIDTH-1:0]   y_in,
  input  logic                     valid_in,
  input  logic                     last_in,
  output logic                     ready_out,
  output logic [WIDTH-1:0]         out,
  output logic                     valid_out,
  input  logic                     ready_in
);
  localparam int LOG2L = $clog2(LANES);
  localparam int ACC_W = 2*WIDTH + LOG2L + 16;
  localparam int PW    = 2*WIDTH;
  localparam int NODES = 2*LANES - 1;

  logic                      w_advance;
  logic [LANES*WIDTH-1:0]    r_x;
  logic [LANES*WIDTH-1:0]    r_y;
  logic                      r_v0;
  logic                      r_last0;
  // Heap-ordered tree: node n sums nodes 2n+1 and 2n+2; leaves hold the products.
  // Every node registers each advance, so each level is one pipeline stage.
  logic signed [ACC_W-1:0]   r_node [NODES];
  logic [LOG2L:0]            r_tv;
  logic [LOG2L:0]            r_tl;
  logic signed [ACC_W-1:0]   r_acc;
  logic [WIDTH-1:0]          r_out;
  logic                      r_valid_out;

  logic signed [PW-1:0]      w_xa   [LANES];
  logic signed [PW-1:0]      w_ya   [LANES];
  logic signed [PW-1:0]      w_prod [LANES];
  logic signed [ACC_W-1:0]   w_leaf [LANES];
  logic signed [ACC_W-1:0]   w_total;
  logic [WIDTH-1:0]          w_reduced;

  assign w_advance = !r_valid_out || ready_in;
  assign ready_out = w_advance;
  assign out       = r_out;
  assign valid_out = r_valid_out;
  assign w_total   = r_acc + r_node[0];

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      w_xa[i]   = {{WIDTH{r_x[i*WIDTH+WIDTH-1]}}, r_x[i*WIDTH +: WIDTH]};
      w_ya[i]   = {{WIDTH{r_y[i*WIDTH+WIDTH-1]}}, r_y[i*WIDTH +: WIDTH]};
      w_prod[i] = w_xa[i] * w_ya[i];
      w_leaf[i] = {{(ACC_W-PW){w_prod[i][PW-1]}}, w_prod[i]};
      if (FIXED_POINT != 0) begin
        w_leaf[i] = w_leaf[i] >>> FRAC;
      end
    end
  end

  always_comb begin
    w_reduced = w_total[WIDTH-1:0];
`ifdef DOT_PRODUCT_SATURATE_EN
    // Fits only when every bit above the result sign bit matches it.
    if (!(&w_total[ACC_W-1:WIDTH-1]) && (|w_total[ACC_W-1:WIDTH-1])) begin
      if (w_total[ACC_W-1]) begin
        w_reduced = {1'b1, {(WIDTH-1){1'b0}}};
      end else begin
        w_reduced = {1'b0, {(WIDTH-1){1'b1}}};
      end
    end
`endif
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_v0        <= 1'b0;
      r_last0     <= 1'b0;
      r_tv        <= '0;
      r_tl        <= '0;
      r_acc       <= '0;
      r_out       <= '0;
      r_valid_out <= 1'b0;
    end else if (w_advance) begin
      r_x     <= x_in;
      r_y     <= y_in;
      r_v0    <= valid_in;
      r_last0 <= valid_in && last_in;
      r_tv    <= {r_tv[LOG2L-1:0], r_v0};
      r_tl    <= {r_tl[LOG2L-1:0], r_last0};
      for (int n = 0; n < LANES-1; n++) begin
        r_node[n] <= r_node[2*n+1] + r_node[2*n+2];
      end
      for (int i = 0; i < LANES; i++) begin
        r_node[LANES-1+i] <= w_leaf[i];
      end
      if (r_tv[LOG2L] && r_tl[LOG2L]) begin
        r_out       <= w_reduced;
        r_valid_out <= 1'b1;
        r_acc       <= '0;
      end else begin
        r_valid_out <= 1'b0;
        if (r_tv[LOG2L]) begin
          r_acc <= w_total;
        end
      end
    end
  end

endmodule

// File: tb/tb_dot_product_stream.sv
// tb/tb_dot_product_stream.sv - scoreboard bench for dot_product_stream (integer and fixed-point instances)
module tb_dot_product_stream;
  localparam int W = 32;
  localparam int L = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [L*W-1:0] x, y;
  logic           vin, lin, rdy_in;
  logic           ro_i, ro_f, vo_i, vo_f;
  logic [W-1:0]   out_i, out_f;

  always #5 clk = ~clk;

  dot_product_stream #(.WIDTH(W), .LANES(L), .FIXED_POINT(0)) dut_int (
    .clk_in(clk), .rst_in(rst), .x_in(x), .y_in(y), .valid_in(vin), .last_in(lin),
    .ready_out(ro_i), .out(out_i), .valid_out(vo_i), .ready_in(rdy_in));

  dot_product_stream #(.WIDTH(W), .LANES(L), .FIXED_POINT(1), .FRAC(16)) dut_fix (
    .clk_in(clk), .rst_in(rst), .x_in(x), .y_in(y), .valid_in(vin), .last_in(lin),
    .ready_out(ro_f), .out(out_f), .valid_out(vo_f), .ready_in(rdy_in));

  int                  checks = 0;
  int                  failures = 0;
  logic [W-1:0]        q_int[$];
  logic [W-1:0]        q_fix[$];
  logic signed [127:0] acc_int = 0;
  logic signed [127:0] acc_fix = 0;
  logic [W-1:0]        last_int = '0;
  logic [W-1:0]        last_fix = '0;
  bit                  rand_ready = 1'b0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: exact dot product in wide arithmetic, then the result reduction.
  function automatic logic signed [127:0] beat_sum(input logic [L*W-1:0] xv, input logic [L*W-1:0] yv,
                                                  input bit fixed);
    logic signed [127:0] s = 0;
    for (int i = 0; i < L; i++) begin
      logic signed [W-1:0]   xa = xv[i*W +: W];
      logic signed [W-1:0]   ya = yv[i*W +: W];
      logic signed [127:0]   a = xa;
      logic signed [127:0]   b = ya;
      logic signed [127:0]   p = a * b;
      if (fixed) p = p >>> 16;
      s = s + p;
    end
    return s;
  endfunction

  function automatic logic [W-1:0] reduce(input logic signed [127:0] v);
    logic signed [127:0] maxv = 128'sh7FFF_FFFF;
    logic signed [127:0] minv = -maxv - 1;
`ifdef DOT_PRODUCT_SATURATE_EN
    if (v > maxv) return 32'h7FFF_FFFF;
    if (v < minv) return 32'h8000_0000;
`endif
    return v[W-1:0];
  endfunction

  always @(negedge clk) begin
    #2;
    if (!rst && vo_i && rdy_in) begin
      if (q_int.size() == 0) begin
        checks++; failures++;
        $display("FAIL int_spurious actual=%0h required=none", out_i);
      end else begin
        check("int_out", out_i, q_int.pop_front());
        last_int = out_i;
      end
    end
    if (!rst && vo_f && rdy_in) begin
      if (q_fix.size() == 0) begin
        checks++; failures++;
        $display("FAIL fix_spurious actual=%0h required=none", out_f);
      end else begin
        check("fix_out", out_f, q_fix.pop_front());
        last_fix = out_f;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    if (rand_ready) rdy_in = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send_beat(input logic [L*W-1:0] xv, input logic [L*W-1:0] yv, input bit last);
    int n = 0;
    tick();
    x = xv; y = yv; lin = last; vin = 1'b1;
    #1;
    while (!ro_i && n < 200) begin
      tick(); #1; n++;
    end
    if (!ro_i) begin
      checks++; failures++;
      $display("FAIL accept_timeout actual=%0d required=1", ro_i);
      vin = 1'b0;
    end else begin
      @(posedge clk);
      #1 vin = 1'b0;
      acc_int = acc_int + beat_sum(xv, yv, 1'b0);
      acc_fix = acc_fix + beat_sum(xv, yv, 1'b1);
      if (last) begin
        q_int.push_back(reduce(acc_int));
        q_fix.push_back(reduce(acc_fix));
        acc_int = 0;
        acc_fix = 0;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      tick();
      vin = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    rand_ready = 1'b0;
    tick();
    rdy_in = 1'b1;
    while ((q_int.size() != 0 || q_fix.size() != 0) && n < 100) begin
      tick(); n++;
    end
    tick();
    check("drain_int_empty", W'(q_int.size()), '0);
    check("drain_fix_empty", W'(q_fix.size()), '0);
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1; vin = 1'b0;
    tick();
    rst = 1'b0;
    acc_int = 0; acc_fix = 0;
    #1;
    check("rst_valid_out", {31'b0, vo_i}, 32'd0);
    check("rst_out", out_i, 32'd0);
    check("rst_ready_out", {31'b0, ro_i}, 32'd1);
    check("rst_fix_valid_out", {31'b0, vo_f}, 32'd0);
  endtask

  function automatic logic [W-1:0] rand_lane();
    if ($urandom_range(0, 1) == 1) return $urandom;
    return W'($urandom_range(0, 2000)) - 32'd1000;
  endfunction

  function automatic logic [L*W-1:0] splat(input logic [W-1:0] v);
    logic [L*W-1:0] r;
    for (int i = 0; i < L; i++) r[i*W +: W] = v;
    return r;
  endfunction

  initial begin
    logic [L*W-1:0] xv, yv;
    int             n;
    rst = 1'b1; vin = 1'b0; lin = 1'b0; x = '0; y = '0; rdy_in = 1'b1;
    do_reset();

    // Single-beat vector: value and latency of exactly 4 edges, one-cycle pulse.
    for (int i = 0; i < L; i++) begin
      xv[i*W +: W] = W'(i + 1);
      yv[i*W +: W] = W'(i + 5);
    end
    send_beat(xv, yv, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      check($sformatf("latency_edge%0d", k), {31'b0, vo_i}, (k == 4) ? 32'd1 : 32'd0);
    end
    check("single_beat_out", last_int, 32'd70);

    // Three beats with a bubble between the first two.
    send_beat(splat(32'd1), splat(32'd2), 1'b0);
    idle(1);
    send_beat(splat(32'd1), splat(32'd2), 1'b0);
    send_beat(splat(32'd1), splat(32'd2), 1'b1);
    drain();
    check("three_beat_out", last_int, 32'd24);

    // Q16.16: 1.5 * 2.0 per lane, four lanes.
    send_beat(splat(32'h0001_8000), splat(32'h0002_0000), 1'b1);
    drain();
    check("fixed_point_out", last_fix, 32'h000C_0000);

    // Back-pressure: three results queued, the first held for five cycles.
    rdy_in = 1'b0;
    for (int v = 0; v < 3; v++) begin
      for (int i = 0; i < L; i++) begin
        xv[i*W +: W] = W'($urandom_range(0, 100)) - 32'd50;
        yv[i*W +: W] = W'($urandom_range(0, 100)) - 32'd50;
      end
      send_beat(xv, yv, 1'b1);
    end
    n = 0;
    while (!vo_i && n < 20) begin
      tick(); #1; n++;
    end
    check("stall_result_arrived", {31'b0, vo_i}, 32'd1);
    repeat (5) begin
      tick(); #1;
      check("stall_valid_out", {31'b0, vo_i}, 32'd1);
      check("stall_out", out_i, q_int[0]);
      check("stall_ready_out", {31'b0, ro_i}, 32'd0);
    end
    drain();

    // Overflowing lanes: wrap or clamp depending on the build.
    send_beat(splat(32'h7FFF_FFFF), splat(32'h7FFF_FFFF), 1'b1);
    drain();
`ifdef DOT_PRODUCT_SATURATE_EN
    check("overflow_out", last_int, 32'h7FFF_FFFF);
`else
    check("overflow_out", last_int, 32'h0000_0004);
`endif

    // Reset discards the partial sum of an unfinished vector.
    send_beat(splat(32'd1), splat(32'd1), 1'b0);
    send_beat(splat(32'd1), splat(32'd1), 1'b0);
    do_reset();
    send_beat(splat(32'd1), splat(32'd3), 1'b1);
    drain();
    check("reset_discard_out", last_int, 32'd12);

    // Random vectors with random gaps and random downstream readiness.
    rand_ready = 1'b1;
    for (int v = 0; v < 40; v++) begin
      int beats = $urandom_range(1, 4);
      for (int b = 0; b < beats; b++) begin
        for (int i = 0; i < L; i++) begin
          xv[i*W +: W] = rand_lane();
          yv[i*W +: W] = rand_lane();
        end
        send_beat(xv, yv, b == beats - 1);
        idle($urandom_range(0, 2));
      end
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dot_product_stream.md
DOT_PRODUCT_STREAM -- requirements
Module: dot_product_stream

Interface
REQ-001 Parameter WIDTH, default 32: signed element and result width, even, >= 8.
REQ-002 Parameter LANES, default 4: elements multiplied per accepted beat, power of two, >= 2.
REQ-003 Parameter FIXED_POINT, default 0: 1 selects Q(WIDTH-FRAC).FRAC arithmetic, 0 selects integer.
REQ-004 Parameter FRAC, default WIDTH/2: fractional bits when FIXED_POINT=1.
REQ-005 clk_in  input  1  the single clock; all logic on its rising edge.
REQ-006 rst_in  input  1  reset, synchronous, active-high.
REQ-007 x_in  input  LANES*WIDTH  signed lanes; lane i at bits [i*WIDTH +: WIDTH].
REQ-008 y_in  input  LANES*WIDTH  signed lanes, same packing as x_in.
REQ-009 valid_in  input  1  beat on x_in/y_in/last_in is valid.
REQ-010 last_in  input  1  beat is the final beat of the current vector.
REQ-011 ready_out  output  1  block accepts a beat this cycle.
REQ-012 out  output  WIDTH  signed dot product of the completed vector.
REQ-013 valid_out  output  1  out holds an unconsumed result.
REQ-014 ready_in  input  1  downstream consumes out when valid_out is high.

Function
REQ-015 A beat SHALL be accepted when valid_in and ready_out are both high.
REQ-016 ready_out SHALL equal (!valid_out || ready_in); the whole pipeline advances only when ready_out is high, otherwise every stage holds.
REQ-017 Stage 1 SHALL register the LANES products x_i*y_i at full 2*WIDTH signed precision.
REQ-018 With FIXED_POINT=1, each product SHALL be arithmetically right-shifted by FRAC (truncation toward minus infinity) before summation.
REQ-019 Products SHALL be summed by a registered binary adder tree of log2(LANES) stages.
REQ-020 Tree, accumulator and all internal sums SHALL be ACC_W = 2*WIDTH+log2(LANES)+16 bits signed; no internal overflow.
REQ-021 The accumulate stage SHALL add each tree sum to the accumulator; beats with valid_in low insert bubbles and do not change the accumulator.
REQ-022 When a last beat reaches the accumulate stage, out SHALL take the reduced value of (accumulator + that sum), valid_out SHALL rise, and the accumulator SHALL clear to 0 in the same cycle.
REQ-023 Latency: the last beat accepted at edge N SHALL produce valid_out high after edge N+log2(LANES)+2 (4 cycles for LANES=4), absent stalls.
REQ-024 Non-last beats SHALL never raise valid_out; a vector may span any number of beats, including one.
REQ-025 valid_out high with ready_in high and a new result arriving in the same cycle SHALL replace out with no bubble; otherwise a consumed result drops valid_out.
REQ-026 While valid_out is high and ready_in is low, out and valid_out SHALL remain stable.

Reset
REQ-027 When rst_in is high at a clock edge, all stage valid flags, the accumulator, out and valid_out SHALL be 0; in-flight beats and partial sums are discarded.
REQ-028 ready_out SHALL be high in the first cycle after reset.

Configuration
REQ-029 Macro DOT_PRODUCT_SATURATE_EN defined: reduction to WIDTH clamps to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-030 Macro DOT_PRODUCT_SATURATE_EN undefined: reduction to WIDTH takes the low WIDTH bits (two's-complement wrap).

Verification (WIDTH=32, LANES=4 unless stated)
REQ-031 Single beat, last=1, x={1,2,3,4}, y={5,6,7,8}, ready_in=1 -> out=70, valid_out high for exactly one cycle, 4 cycles after acceptance.
REQ-032 Three beats, x all 1, y all 2, last on third, one idle bubble between beats 1 and 2 -> single result out=24.
REQ-033 FIXED_POINT=1, FRAC=16, x lanes 0x00018000, y lanes 0x00020000, last=1 -> out=0x000C0000.
REQ-034 Result pending, ready_in low 5 cycles -> out/valid_out stable, ready_out low; next two queued vectors emerge in order with correct values.
REQ-035 x and y lanes 0x7FFFFFFF, last=1 -> out=0x7FFFFFFF with DOT_PRODUCT_SATURATE_EN, out=0x00000004 without.
REQ-036 Two non-last beats of x=y=all 1, then rst_in one cycle, then one last beat x={1,1,1,1}, y={3,3,3,3} -> out=12.
